heart_pulse_timer: RTL and testbench
====================================

// Module: heart_pulse_timer
// PURPOSE
//  Measures the interval between heartbeat pulses from the raw sensor input and presents the results as 8-bit words.
//  Sits directly upstream of the data memory's memory-mapped input ports: PERIOD drives IOA (addr 249),
//  STATUS drives IOB (addr 250) and BEATS drives IOC (addr 251). EN is driven from IOD[0] (addr 252).
//  Firmware converts PERIOD to BPM using the BCD lookup table held in memory.
// PARAMETERS
//  PRESCALE    500000  clock cycles per tick (10 ms at 50 MHz); must be >= 2
//  DEB_TICKS   2       ticks the synchronised input must be stable before the debounced level changes
//  MIN_PERIOD  25      refractory period in ticks; rising edges with CNT < MIN_PERIOD are ignored
// PORTS
//  CLK      in   1  system clock; the only clock domain
//  RESET_N  in   1  synchronous, active-low reset
//  PULSE    in   1  raw sensor pulse, asynchronous to CLK
//  EN       in   1  measurement enable (IOD[0])
//  PERIOD   out  8  last valid beat-to-beat interval in ticks
//  STATUS   out  8  [0] VALID, [1] TIMEOUT, [2] BEAT toggle, [7:3] = 0
//  BEATS    out  8  count of accepted beats, wraps 255 -> 0
// BEHAVIOUR
//  Reset (RESET_N=0 at a CLK edge)
//   - PERIOD, STATUS, BEATS, prescaler, CNT, debounce state and sync flops all go to 0; FSM -> IDLE.
//   - Reset overrides every other event in the same cycle, including mid-measurement.
//  Input path
//   - PULSE passes through a 2-flop synchroniser.
//   - TICK is a 1-cycle strobe when the prescaler equals PRESCALE-1; the prescaler then wraps to 0.
//   - The debounced level DEB takes the synchronised value after DEB_TICKS consecutive ticks of agreement.
//     Any disagreement restarts the stability count.
//   - EDGE = DEB rising edge, registered. EDGE is asserted exactly one cycle.
//  Period counter CNT (8 bit)
//   - Increments on TICK and saturates at 255.
//   - Loads 0 on an accepted beat; the load wins over a coincident TICK.
//  FSM
//   - IDLE: CNT held at 0; VALID=0; PERIOD and BEATS held. EN=1 -> ARM.
//   - ARM: the first EDGE is accepted: CNT<=0, BEATS+1, BEAT toggles, TIMEOUT<=0. Then -> MEAS.
//   - MEAS, EDGE with CNT>=MIN_PERIOD: PERIOD<=CNT, VALID<=1, CNT<=0, BEATS+1, BEAT toggles. Stay in MEAS.
//   - MEAS, EDGE with CNT<MIN_PERIOD: the edge is ignored (no output change, CNT keeps counting).
//   - MEAS, CNT reaches 255: TIMEOUT<=1, VALID<=0, PERIOD<=0, CNT<=0. Then -> ARM.
//   - EN=0 in any state -> IDLE next cycle. This takes priority over a coincident EDGE or timeout.
//  Timing and readout
//   - Outputs are registered. PERIOD, STATUS and BEATS update 1 cycle after the EDGE cycle.
//   - Total latency from a PULSE rise to the output update: 2 sync cycles + DEB_TICKS ticks + 2 cycles.
//   - Memory loads see stable registered values; there is no read side effect.
// STRUCTURE
//  - Shared package: FSM state encoding (IDLE/ARM/MEAS) and the STATUS bit indices (ST_VALID=0,
//    ST_TIMEOUT=1, ST_BEAT=2), so firmware headers and the bench share one source.
//  - Sub-module pulse_debouncer (sync + stability counter, with TICK and DEB_TICKS inputs, outputs DEB and EDGE).
//  - Top level holds the prescaler, CNT, FSM and output registers.
// TESTING  (bench parameters: PRESCALE=4, DEB_TICKS=2, MIN_PERIOD=3)
//  1. Reset: hold RESET_N=0 while PULSE toggles and EN=1 -> PERIOD=0, STATUS=0, BEATS=0.
//     Release reset -> FSM in IDLE for 1 cycle, then ARM.
//  2. EN=1, PULSE high for 20 cycles every 40 cycles (5 beats) -> BEATS=5, PERIOD=10, STATUS=8'h05.
//     VALID is set after the 2nd beat, and the BEAT bit toggles on each beat.
//  3. Glitch: a 3-cycle high pulse on PULSE (shorter than 2 ticks) between beats -> no EDGE, BEATS and PERIOD unchanged.
//  4. Refractory: an edge 2 ticks after an accepted beat (2 < MIN_PERIOD=3) -> ignored, PERIOD unchanged.
//     The next edge at 10 ticks gives PERIOD=10.
//  5. Timeout: after one beat, hold PULSE low for 1100 cycles -> at CNT=255: STATUS=8'h02, PERIOD=0, FSM ARM.
//     The next beat clears TIMEOUT and increments BEATS.
//  6. EN dropped the same cycle as EDGE -> beat not counted, VALID=0, PERIOD and BEATS held.
//     BEATS wrap: 256 accepted beats -> BEATS returns to 0.

Source files
------------

// File: rtl/heart_pulse_timer_pkg.sv
// Shared definitions for the heartbeat interval timer: FSM encoding, STATUS
// bit positions and the status-word packing used by RTL and bench alike.
package heart_pulse_timer_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StArm  = 2'd1,
        StMeas = 2'd2
    } hpt_state_e;

    // STATUS word bit positions; [7:3] read as zero.
    localparam int unsigned StValid   = 0;
    localparam int unsigned StTimeout = 1;
    localparam int unsigned StBeat    = 2;

    // Period counter saturation value; reaching it means no beat was seen.
    localparam logic [7:0] CntMax = 8'hFF;

    // Width of the debounce stability counter and its threshold input.
    localparam int unsigned DebW = 8;

    function automatic logic [7:0] pack_status(input logic valid, input logic timeout,
                                               input logic beat);
        logic [7:0] s;
        s            = '0;
        s[StValid]   = valid;
        s[StTimeout] = timeout;
        s[StBeat]    = beat;
        return s;
    endfunction

endpackage

// File: rtl/heart_pulse_timer_pulse_debouncer.sv
// Synchronises the raw sensor pulse and debounces it on prescaler ticks.
// edge_o is a one-cycle strobe in the cycle the debounced level first reads high.
module heart_pulse_timer_pulse_debouncer
    import heart_pulse_timer_pkg::*;
(
    input  logic            clk_i,
    input  logic            reset_ni,
    input  logic            pulse_i,
    input  logic            tick_i,
    input  logic [DebW-1:0] deb_ticks_i,
    output logic            deb_o,
    output logic            edge_o
);

    logic            sync1_q, sync2_q;
    logic            deb_q, edge_q;
    logic [DebW-1:0] stab_q;

    // Two-flop synchroniser, then count ticks of disagreement before adopting the new level.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            edge_q  <= 1'b0;
            stab_q  <= '0;
        end else begin
            sync1_q <= pulse_i;
            sync2_q <= sync1_q;
            edge_q  <= 1'b0;
            if (sync2_q == deb_q) begin
                // Agreement with the current level restarts the stability count.
                stab_q <= '0;
            end else if (tick_i) begin
                if ((stab_q + DebW'(1)) >= deb_ticks_i) begin
                    deb_q  <= sync2_q;
                    edge_q <= sync2_q;
                    stab_q <= '0;
                end else begin
                    stab_q <= stab_q + DebW'(1);
                end
            end
        end
    end

    assign deb_o  = deb_q;
    assign edge_o = edge_q;

endmodule

// File: rtl/heart_pulse_timer.sv
// Heartbeat interval timer: prescaler, tick-based period counter and the
// IDLE/ARM/MEAS state machine that publishes PERIOD, STATUS and BEATS words.
module heart_pulse_timer
    import heart_pulse_timer_pkg::*;
#(
    parameter int unsigned Prescale  = 500000,
    parameter int unsigned DebTicks  = 2,
    parameter int unsigned MinPeriod = 25
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic       pulse_i,
    input  logic       en_i,
    output logic [7:0] period_o,
    output logic [7:0] status_o,
    output logic [7:0] beats_o
);

    localparam int unsigned PreW = (Prescale > 1) ? $clog2(Prescale) : 1;

    logic [PreW-1:0] presc_q, presc_d;
    logic            tick_w;
    logic            deb_w, edge_w, beat_edge_w;

    hpt_state_e      state_q;
    logic [7:0]      cnt_q, cnt_tick_d;
    logic [7:0]      period_q, beats_q;
    logic            valid_q, timeout_q, beat_q;

    assign tick_w  = (presc_q == PreW'(Prescale - 1));
    assign presc_d = tick_w ? '0 : presc_q + PreW'(1);

    // Free-running prescaler producing the tick strobe.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    heart_pulse_timer_pulse_debouncer u_debouncer (
        .clk_i       (clk_i),
        .reset_ni    (reset_ni),
        .pulse_i     (pulse_i),
        .tick_i      (tick_w),
        .deb_ticks_i (DebW'(DebTicks)),
        .deb_o       (deb_w),
        .edge_o      (edge_w)
    );

    // Only treat the strobe as a beat while the debounced level is actually high.
    assign beat_edge_w = edge_w & deb_w;

    // Saturating tick count used whenever no load to zero happens.
    assign cnt_tick_d = (tick_w && (cnt_q != CntMax)) ? cnt_q + 8'd1 : cnt_q;

    // Measurement FSM with its registered output words; EN low outranks everything but reset.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            period_q  <= '0;
            beats_q   <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            beat_q    <= 1'b0;
        end else if (!en_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    cnt_q   <= '0;
                    valid_q <= 1'b0;
                    state_q <= StArm;
                end
                StArm: begin
                    cnt_q <= '0;
                    if (beat_edge_w) begin
                        beats_q   <= beats_q + 8'd1;
                        beat_q    <= ~beat_q;
                        timeout_q <= 1'b0;
                        state_q   <= StMeas;
                    end
                end
                StMeas: begin
                    if (beat_edge_w && (cnt_q >= 8'(MinPeriod))) begin
                        period_q <= cnt_q;
                        valid_q  <= 1'b1;
                        cnt_q    <= '0;
                        beats_q  <= beats_q + 8'd1;
                        beat_q   <= ~beat_q;
                    end else if (cnt_q == CntMax) begin
                        timeout_q <= 1'b1;
                        valid_q   <= 1'b0;
                        period_q  <= '0;
                        cnt_q     <= '0;
                        state_q   <= StArm;
                    end else begin
                        // Refractory edges fall through here and the count keeps running.
                        cnt_q <= cnt_tick_d;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign period_o = period_q;
    assign status_o = pack_status(valid_q, timeout_q, beat_q);
    assign beats_o  = beats_q;

endmodule

// File: tb/tb_heart_pulse_timer.sv
// Directed bench for heart_pulse_timer with hand-computed expected words.
// A second instance with a one-tick debounce exercises the refractory window.
module tb_heart_pulse_timer;
    import heart_pulse_timer_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       en = 1'b0;
    logic       pulse = 1'b0;
    logic       pulse2 = 1'b0;
    logic [7:0] period, status, beats;
    logic [7:0] period2, status2, beats2;
    int         tests_run = 0;
    int         tests_failed = 0;

    always #5 clk = ~clk;

    heart_pulse_timer #(
        .Prescale  (4),
        .DebTicks  (2),
        .MinPeriod (3)
    ) dut (
        .clk_i    (clk),
        .reset_ni (reset_n),
        .pulse_i  (pulse),
        .en_i     (en),
        .period_o (period),
        .status_o (status),
        .beats_o  (beats)
    );

    heart_pulse_timer #(
        .Prescale  (4),
        .DebTicks  (1),
        .MinPeriod (3)
    ) dut2 (
        .clk_i    (clk),
        .reset_ni (reset_n),
        .pulse_i  (pulse2),
        .en_i     (en),
        .period_o (period2),
        .status_o (status2),
        .beats_o  (beats2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic beat(input int hi, input int lo);
        pulse = 1'b1;
        cycles(hi);
        pulse = 1'b0;
        cycles(lo);
    endtask

    task automatic beat2(input int hi, input int lo);
        pulse2 = 1'b1;
        cycles(hi);
        pulse2 = 1'b0;
        cycles(lo);
    endtask

    task automatic check_main(input string tag, input logic [7:0] exp_period,
                              input logic [7:0] exp_status, input logic [7:0] exp_beats);
        check_eq({tag, "_period"}, 32'(period), 32'(exp_period));
        check_eq({tag, "_status"}, 32'(status), 32'(exp_status));
        check_eq({tag, "_beats"}, 32'(beats), 32'(exp_beats));
    endtask

    initial begin
        logic found;

        // 1. Reset held with activity on the inputs.
        reset_n = 1'b0;
        en      = 1'b1;
        repeat (6) begin
            @(negedge clk);
            pulse = ~pulse;
        end
        check_main("rst", 8'd0, 8'h00, 8'd0);
        check_eq("rst_state", 32'(dut.state_q), 32'(StIdle));
        @(negedge clk);
        pulse   = 1'b0;
        reset_n = 1'b1;
        check_eq("rel_idle", 32'(dut.state_q), 32'(StIdle));
        cycles(1);
        check_eq("rel_arm", 32'(dut.state_q), 32'(StArm));
        cycles(4);

        // 2. Five beats 40 cycles (10 ticks) apart.
        beat(20, 20);
        check_main("b1", 8'd0, 8'h04, 8'd1);
        beat(20, 20);
        check_main("b2", 8'd10, 8'h01, 8'd2);
        beat(20, 20);
        beat(20, 20);
        beat(20, 20);
        check_main("b5", 8'd10, 8'h05, 8'd5);

        // 3. A 3-cycle glitch between beats must not register.
        beat(3, 37);
        check_main("glitch", 8'd10, 8'h05, 8'd5);
        beat(20, 20);
        check_main("b6", 8'd20, 8'h01, 8'd6);

        // 4. Refractory: edge 2 ticks after a beat ignored, next at 10 ticks measured.
        beat2(4, 4);
        beat2(4, 28);
        check_eq("refr_beats", 32'(beats2), 32'd1);
        check_eq("refr_period", 32'(period2), 32'd0);
        check_eq("refr_status", 32'(status2), 32'h04);
        beat2(4, 36);
        check_eq("refr_next_beats", 32'(beats2), 32'd2);
        check_eq("refr_next_period", 32'(period2), 32'd10);
        check_eq("refr_next_status", 32'(status2), 32'h01);

        // 5. Timeout: no beat for well over 255 ticks.
        cycles(880);
        check_main("pre_to", 8'd20, 8'h01, 8'd6);
        cycles(200);
        check_main("to", 8'd0, 8'h02, 8'd6);
        check_eq("to_state", 32'(dut.state_q), 32'(StArm));
        beat(20, 20);
        check_main("after_to", 8'd0, 8'h04, 8'd7);
        beat(20, 20);
        check_main("b8", 8'd10, 8'h01, 8'd8);

        // 6. EN dropped in the same cycle the edge is presented.
        pulse = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (dut.edge_w) found = 1'b1;
        end
        check_eq("en_edge_seen", 32'(found), 32'd1);
        en = 1'b0;
        cycles(8);
        pulse = 1'b0;
        cycles(20);
        check_main("en_drop", 8'd10, 8'h00, 8'd8);
        check_eq("en_drop_state", 32'(dut.state_q), 32'(StIdle));
        en = 1'b1;
        cycles(2);

        // Reset mid-run clears everything, then BEATS wraps after 256 beats.
        reset_n = 1'b0;
        cycles(2);
        check_main("rst2", 8'd0, 8'h00, 8'd0);
        reset_n = 1'b1;
        cycles(4);
        for (int i = 0; i < 255; i++) beat(12, 12);
        check_main("b255", 8'd6, 8'h05, 8'd255);
        beat(12, 12);
        check_main("wrap", 8'd6, 8'h01, 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
